bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 14-bit binary to 4-digit BCD converter (double dabble).
//
// One conversion takes exactly 14 shift cycles plus one result-load cycle.
// Inputs above 9999 saturate the digits to 9999 and raise ovf_o.
//
// Ports:
//   clk_i      system clock, rising-edge active
//   rst_i      synchronous active-high reset
//   start_i    conversion request, sampled only while idle
//   bin_i      14-bit unsigned value, captured on the accepted start edge
//   busy_o     high while a conversion is in flight (shift or load state)
//   done_o     one-cycle pulse when new digits are presented
//   ovf_o      last completed conversion exceeded 9999
//   dig1000_o  BCD thousands digit of the last completed conversion
//   dig100_o   BCD hundreds digit
//   dig10_o    BCD tens digit
//   dig1_o     BCD units digit
module bin2bcd_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovf_o,
    output logic [3:0]  dig1000_o,
    output logic [3:0]  dig100_o,
    output logic [3:0]  dig10_o,
    output logic [3:0]  dig1_o
);

    localparam int unsigned BinW    = 14;
    localparam int unsigned BcdW    = 16;
    localparam int unsigned NumDigs = 4;

    // Counter value on the edge that performs the final (14th) shift.
    localparam logic [3:0]      LastCnt = 4'd13;
    localparam logic [BinW-1:0] MaxDec  = 14'd9999;
    localparam logic [BcdW-1:0] SatBcd  = 16'h9999;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [BinW-1:0]   bin_q, bin_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [BcdW-1:0]   dig_q, dig_d;

    // Scratch after the add-3 correction, before the shift.
    logic [BcdW-1:0]   bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NumDigs; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        dig_d      = dig_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    bin_d      = bin_i;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (bin_i > MaxDec);
                    state_d    = StShift;
                end
            end

            StShift: begin
                // {bcd, bin} shifted left as one 30-bit register; scratch MSB is dropped.
                bcd_d = {bcd_adj[BcdW-2:0], bin_q[BinW-1]};
                bin_d = {bin_q[BinW-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                done_d  = 1'b1;
                ovf_d   = ovf_pend_q;
                dig_d   = ovf_pend_q ? SatBcd : bcd_q;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign ovf_o     = ovf_q;
    assign dig1000_o = dig_q[15:12];
    assign dig100_o  = dig_q[11:8];
    assign dig10_o   = dig_q[7:4];
    assign dig1_o    = dig_q[3:0];

endmodule
